tdm_demux8: RTL and testbench

- Receiving end of the 8-to-1 multiplexer path.
- The mux side serialises eight channels onto one line, slot by slot (slot 0 first, marked by a frame sync).
- This block deserialises that time-division stream back into eight parallel registered channels.
- Outputs update atomically once per complete frame; the block detects sync loss and resynchronises.

---
 rtl/tdm_demux8.sv | 145 ++++++++++++++
 tb/tb_tdm_demux8.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive side of an 8-slot time-division line.
// Collects slots 0..7 of each frame into shadow registers and publishes all
// eight channels together when slot 7 arrives. A sync on any slot but 0
// restarts the frame. A slot 0 that arrives without sync drops the lock and
// sends the block back to hunting for sync. Framing errors are counted in a
// saturating counter.
module tdm_demux8 #(
    parameter int WIDTH = 1,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic             frame_valid,
    output logic             locked,
    output logic [2:0]       slot,
    output logic             sync_err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Saturating increment: holds at all-ones instead of wrapping to zero
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == {ERR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_e           state_q;
    logic [2:0]       slot_q;
    logic             locked_q;
    logic             frame_valid_q;
    logic             sync_err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [WIDTH-1:0] shadow_q [8];
    logic [WIDTH-1:0] out_q    [8];

    // Framing FSM: slot tracking, shadow capture, atomic publish, error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            slot_q        <= 3'd0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_cnt_q     <= {ERR_W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= {WIDTH{1'b0}};
                out_q[i]    <= {WIDTH{1'b0}};
            end
        end else begin
            // Pulses last one cycle unless re-armed below
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        if (frame_sync) begin
                            shadow_q[0] <= din;
                            slot_q      <= 3'd1;
                            state_q     <= ST_LOCKED;
                            locked_q    <= 1'b1;
                        end else begin
                            // Not aligned yet: drop the sample quietly
                            slot_q <= 3'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (frame_sync) begin
                            // Sync always restarts the frame; off slot 0 it
                            // is an early sync and the partial frame is lost
                            if (slot_q != 3'd0) begin
                                sync_err_q <= 1'b1;
                                err_cnt_q  <= sat_inc(err_cnt_q);
                            end else begin
                                sync_err_q <= 1'b0;
                            end
                            shadow_q[0] <= din;
                            slot_q      <= 3'd1;
                        end else if (slot_q == 3'd0) begin
                            // Slot 0 without sync: alignment lost
                            sync_err_q <= 1'b1;
                            err_cnt_q  <= sat_inc(err_cnt_q);
                            slot_q     <= 3'd0;
                            state_q    <= ST_HUNT;
                            locked_q   <= 1'b0;
                        end else if (slot_q == 3'd7) begin
                            // Last slot: publish the whole frame on one edge
                            for (int i = 0; i < 7; i++) begin
                                out_q[i] <= shadow_q[i];
                            end
                            out_q[7]      <= din;
                            frame_valid_q <= 1'b1;
                            slot_q        <= 3'd0;
                        end else begin
                            shadow_q[slot_q] <= din;
                            slot_q           <= slot_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q  <= ST_HUNT;
                        slot_q   <= 3'd0;
                        locked_q <= 1'b0;
                    end
                endcase
            end else begin
                // No valid slot this cycle: everything holds
                state_q <= state_q;
            end
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign out4        = out_q[4];
    assign out5        = out_q[5];
    assign out6        = out_q[6];
    assign out7        = out_q[7];
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign slot        = slot_q;
    assign sync_err    = sync_err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8 (WIDTH=1). A second instance with ERR_W=2
// shares the inputs so that counter saturation can be observed.
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic       o0, o1, o2, o3, o4, o5, o6, o7;
    logic       frame_valid, locked, sync_err;
    logic [2:0] slot;
    logic [7:0] err_cnt;
    logic       p0, p1, p2, p3, p4, p5, p6, p7;
    logic       fv2, lk2, se2;
    logic [2:0] slot2;
    logic [1:0] err_cnt2;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_demux8 #(.WIDTH(1), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync),
        .out0(o0), .out1(o1), .out2(o2), .out3(o3),
        .out4(o4), .out5(o5), .out6(o6), .out7(o7),
        .frame_valid(frame_valid), .locked(locked), .slot(slot),
        .sync_err(sync_err), .err_cnt(err_cnt)
    );

    tdm_demux8 #(.WIDTH(1), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync),
        .out0(p0), .out1(p1), .out2(p2), .out3(p3),
        .out4(p4), .out5(p5), .out6(p6), .out7(p7),
        .frame_valid(fv2), .locked(lk2), .slot(slot2),
        .sync_err(se2), .err_cnt(err_cnt2)
    );

    // outs[N] is channel N
    assign outs = {o7, o6, o5, o4, o3, o2, o1, o0};

    // Present one input cycle and sample just after the rising edge
    task automatic step(input logic v, input logic fs, input logic d);
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (outs !== 8'h00) begin errors++; $display("FAIL reset_outs got=%h exp=00", outs); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (slot !== 3'd0) begin errors++; $display("FAIL reset_slot got=%0d exp=0", slot); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
        checks++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin errors++;
            $display("FAIL reset_pulses got fv=%b se=%b exp 0 0", frame_valid, sync_err); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Frame 1,0,1,1,0,0,1,0 on slots 0..7 -> outs = 8'h4D
    task automatic test_basic_frame();
        logic [7:0] bits;
        bits = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? 1'b1 : 1'b0, bits[i]);
            if (i == 6) begin
                checks++; if (frame_valid !== 1'b0 || outs !== 8'h00) begin errors++;
                    $display("FAIL basic_early_update got fv=%b outs=%h exp 0 00", frame_valid, outs); end
                checks++; if (slot !== 3'd7) begin errors++; $display("FAIL basic_slot7 got=%0d exp=7", slot); end
            end
        end
        checks++; if (outs !== 8'h4D) begin errors++; $display("FAIL basic_outs got=%h exp=4d", outs); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_fv got=%b exp=1", frame_valid); end
        checks++; if (locked !== 1'b1 || err_cnt !== 8'd0 || slot !== 3'd0) begin errors++;
            $display("FAIL basic_state got lk=%b ec=%0d slot=%0d exp 1 0 0", locked, err_cnt, slot); end
        step(1'b0, 1'b0, 1'b0);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL basic_fv_pulse got=%b exp=0", frame_valid); end
    endtask

    // Same frame with a 3-cycle invalid gap between slots 3 and 4; junk on
    // din/frame_sync during the gap must be ignored
    task automatic test_gap();
        logic [7:0] bits;
        int fv_cnt;
        bits = 8'b0100_1101;
        fv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0) ? 1'b1 : 1'b0, bits[i]);
            if (frame_valid === 1'b1) fv_cnt++;
        end
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1, ~bits[4]);
            if (frame_valid === 1'b1) fv_cnt++;
            checks++; if (slot !== 3'd4) begin errors++; $display("FAIL gap_slot_hold cyc=%0d got=%0d exp=4", g, slot); end
        end
        for (int i = 4; i < 8; i++) begin
            step(1'b1, 1'b0, bits[i]);
            if (frame_valid === 1'b1) fv_cnt++;
        end
        checks++; if (outs !== 8'h4D || frame_valid !== 1'b1) begin errors++;
            $display("FAIL gap_outs got outs=%h fv=%b exp 4d 1", outs, frame_valid); end
        checks++; if (fv_cnt != 1) begin errors++; $display("FAIL gap_fv_count got=%0d exp=1", fv_cnt); end
    endtask

    // Sync at slot 5 restarts the frame; data 1 becomes new slot 0
    task automatic test_early_sync();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        checks++; if (sync_err !== 1'b1 || err_cnt !== 8'd1) begin errors++;
            $display("FAIL early_err got se=%b ec=%0d exp 1 1", sync_err, err_cnt); end
        checks++; if (slot !== 3'd1 || outs !== 8'h4D || locked !== 1'b1) begin errors++;
            $display("FAIL early_state got slot=%0d outs=%h lk=%b exp 1 4d 1", slot, outs, locked); end
        // slots 1..7 = 1,1,0,0,1,1,0 -> channels 1,1,1,0,0,1,1,0 = 8'h67
        step(1'b1, 1'b0, 1'b1);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL early_err_pulse got=%b exp=0", sync_err); end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        checks++; if (outs !== 8'h67 || frame_valid !== 1'b1) begin errors++;
            $display("FAIL early_recover got outs=%h fv=%b exp 67 1", outs, frame_valid); end
    endtask

    // Slot 0 without sync drops lock; samples ignored until the next sync
    task automatic test_missing_sync();
        step(1'b1, 1'b0, 1'b1);
        checks++; if (sync_err !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0 || slot !== 3'd0) begin errors++;
            $display("FAIL missing_err got se=%b ec=%0d lk=%b slot=%0d exp 1 2 0 0", sync_err, err_cnt, locked, slot); end
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, i[0]);
            checks++; if (sync_err !== 1'b0 || locked !== 1'b0 || slot !== 3'd0 || frame_valid !== 1'b0) begin errors++;
                $display("FAIL hunt_ignore i=%0d got se=%b lk=%b slot=%0d fv=%b", i, sync_err, locked, slot, frame_valid); end
        end
        checks++; if (outs !== 8'h67 || err_cnt !== 8'd2) begin errors++;
            $display("FAIL hunt_hold got outs=%h ec=%0d exp 67 2", outs, err_cnt); end
        // channels 0,1,0,1,0,1,0,1 -> 8'hAA
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0) ? 1'b1 : 1'b0, i[0]);
        checks++; if (outs !== 8'hAA || frame_valid !== 1'b1 || locked !== 1'b1) begin errors++;
            $display("FAIL relock got outs=%h fv=%b lk=%b exp aa 1 1", outs, frame_valid, locked); end
    endtask

    // Asynchronous reset at slot 4, then a clean frame
    task automatic test_reset_mid();
        logic [7:0] bits;
        bits = 8'b0100_1101;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++; if (slot !== 3'd4) begin errors++; $display("FAIL mid_slot got=%0d exp=4", slot); end
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (outs !== 8'h00 || locked !== 1'b0 || slot !== 3'd0 || err_cnt !== 8'd0) begin errors++;
            $display("FAIL mid_reset got outs=%h lk=%b slot=%0d ec=%0d exp 00 0 0 0", outs, locked, slot, err_cnt); end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0) ? 1'b1 : 1'b0, bits[i]);
        checks++; if (outs !== 8'h4D || frame_valid !== 1'b1 || err_cnt !== 8'd0) begin errors++;
            $display("FAIL mid_decode got outs=%h fv=%b ec=%0d exp 4d 1 0", outs, frame_valid, err_cnt); end
    endtask

    // Five early syncs: 8-bit counter reaches 5, 2-bit counter sticks at 3
    task automatic test_saturation();
        logic [1:0] exp2;
        apply_reset();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            exp2 = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++; if (err_cnt !== 8'(i + 1) || err_cnt2 !== exp2) begin errors++;
                $display("FAIL sat_cnt i=%0d got ec=%0d ec2=%0d exp %0d %0d", i, err_cnt, err_cnt2, i + 1, exp2); end
        end
    endtask

    // Two frames with din_valid held high: frame_valid on samples 8 and 16
    task automatic test_back_to_back();
        int fv_cnt;
        apply_reset();
        fv_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 8 == 0) ? 1'b1 : 1'b0, (i < 8) ? 1'b1 : ((i % 2 == 1) ? 1'b1 : 1'b0));
            if (frame_valid === 1'b1) fv_cnt++;
            if (i == 7) begin
                checks++; if (outs !== 8'hFF || frame_valid !== 1'b1) begin errors++;
                    $display("FAIL b2b_first got outs=%h fv=%b exp ff 1", outs, frame_valid); end
            end
        end
        checks++; if (outs !== 8'hAA || frame_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_second got outs=%h fv=%b exp aa 1", outs, frame_valid); end
        checks++; if (fv_cnt != 2 || err_cnt !== 8'd0) begin errors++;
            $display("FAIL b2b_count got fv=%0d ec=%0d exp 2 0", fv_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gap();
        test_early_sync();
        test_missing_sync();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
